// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the five-stage pipeline: global stage enable, halt drain, executed-cycle counter.
// Optional RUN-mode watchdog is built when RUN_CTRL_WATCHDOG_EN is defined.
module pipeline_run_ctrl #(
    parameter int DRAIN_CYCLES    = 4,
    parameter int NB_CYCLE_CNT    = 32,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_step,
    input  logic                    i_abort,
    input  logic                    i_halt_detected,
    output logic                    o_enable,
    output logic                    o_halt_fetch,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [2:0]              o_state,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int              DC_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

    logic [2:0]              state_reg;
    logic [2:0]              state_next;
    logic [DC_W-1:0]         drain_cnt_reg;
    logic [NB_CYCLE_CNT-1:0] cycle_cnt_reg;
    logic                    wd_hit;
    logic                    leave_done;

    assign leave_done = (state_reg == ST_DONE) && i_abort;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_RUN;
                end else if (i_step) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_next = ST_IDLE;
                end else if (i_halt_detected || wd_hit) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (i_abort) begin
                    state_next = ST_IDLE;
                end else if (i_halt_detected) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    state_next = ST_IDLE;
                end else if (drain_cnt_reg == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_abort) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_enable      = 1'b0;
        o_halt_fetch  = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_state       = state_reg;
        o_cycle_count = cycle_cnt_reg;
        case (state_reg)
            ST_RUN, ST_STEP: begin
                o_enable = 1'b1;
                o_busy   = 1'b1;
            end
            ST_DRAIN: begin
                o_enable     = 1'b1;
                o_busy       = 1'b1;
                o_halt_fetch = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Drain counter loads on any entry into DRAIN (halt from RUN/STEP or watchdog).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            drain_cnt_reg <= '0;
            cycle_cnt_reg <= '0;
        end else begin
            if (leave_done) begin
                cycle_cnt_reg <= '0;
            end else if (o_enable) begin
                cycle_cnt_reg <= cycle_cnt_reg + NB_CYCLE_CNT'(1);
            end

            if ((state_next == ST_DRAIN) && (state_reg != ST_DRAIN)) begin
                drain_cnt_reg <= DRAIN_LOAD;
            end else if ((state_reg == ST_DRAIN) && (drain_cnt_reg != '0)) begin
                drain_cnt_reg <= drain_cnt_reg - DC_W'(1);
            end
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam int              WD_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_reg;

    // Hit on the edge that ends the WATCHDOG_CYCLES-th enabled RUN cycle.
    assign wd_hit = (wd_cnt_reg == WD_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && (state_next == ST_RUN)) begin
                wd_cnt_reg <= '0;
            end else if ((state_reg == ST_RUN) && !wd_hit) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end

            if ((state_reg == ST_RUN) && (state_next == ST_DRAIN) && !i_halt_detected) begin
                timeout_reg <= 1'b1;
            end else if (leave_done) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign wd_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule
